// File: rtl/pistorm_pkg.sv
// ============================================================================
// Module      : pistorm_pkg
// Description : Shared types and widths for the PiStorm operation queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pistorm_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              rw;
        logic              uds_n;
        logic              lds_n;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } issue_state_t;

endpackage

`default_nettype wire

// File: rtl/pistorm_sync_fifo.sv
// ============================================================================
// Module      : pistorm_sync_fifo
// Description : Power-of-two synchronous FIFO of op_entry_t with a
//               combinational head output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pistorm_sync_fifo
    import pistorm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  op_entry_t              i_wdata,
    input  logic                   i_pop,
    output op_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(DEPTH);

    op_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Guarding here keeps count inside 0..DEPTH whatever the caller does.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/pistorm_op_queue.sv
// ============================================================================
// Module      : pistorm_op_queue
// Description : Queues Pi-side 68k operations and issues them one at a time
//               to the bus engine. Define PISTORM_POSTED_WRITE_EN to let
//               writes post into the queue while a cycle is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pistorm_op_queue
    import pistorm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   c200m,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_rw,
    input  logic [23:0]            in_addr,
    input  logic [15:0]            in_data,
    input  logic                   in_uds_n,
    input  logic                   in_lds_n,
    output logic                   bus_req,
    output logic                   bus_rw,
    output logic [23:0]            bus_addr,
    output logic [15:0]            bus_data,
    output logic                   bus_uds_n,
    output logic                   bus_lds_n,
    input  logic                   bus_done,
    input  logic [15:0]            bus_rdata,
    output logic                   rd_valid,
    output logic [15:0]            rd_data,
    output logic                   idle,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_stray
);

    localparam op_entry_t c_BUS_RST = '{rw: 1'b1, uds_n: 1'b1, lds_n: 1'b1,
                                        addr: '0, data: '0};

    issue_state_t r_state;
    issue_state_t w_next;
    op_entry_t    w_in_entry;
    op_entry_t    w_head;
    op_entry_t    r_bus;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    logic         w_issue;
    logic         w_pop;
    logic         w_stray;
    logic         w_ready_mode;
    logic         r_bus_req;
    logic         r_rd_pending;
    logic         r_rd_valid;
    logic [15:0]  r_rd_data;
    logic         r_err_stray;

    assign w_in_entry = '{rw: in_rw, uds_n: in_uds_n, lds_n: in_lds_n,
                          addr: in_addr, data: in_data};

`ifdef PISTORM_POSTED_WRITE_EN
    assign w_ready_mode = 1'b1;
`else
    // Only one operation may be outstanding: queue empty and no cycle in flight.
    assign w_ready_mode = w_empty && (r_state == ST_IDLE);
`endif

    assign in_ready = !reset && !w_full && !r_rd_pending && w_ready_mode;
    assign w_push   = in_valid && in_ready;

    pistorm_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (c200m),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (w_in_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge c200m) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (!w_empty) w_next = ST_WAIT;
            ST_WAIT: if (bus_done) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue = (r_state == ST_IDLE) && !w_empty;
        w_pop   = (r_state == ST_WAIT) && bus_done;
        w_stray = (r_state != ST_WAIT) && bus_done;
    end

    // Head fields are captured at issue so they hold steady through the cycle.
    always_ff @(posedge c200m) begin
        if (reset) begin
            r_bus_req    <= 1'b0;
            r_bus        <= c_BUS_RST;
            r_rd_pending <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_err_stray  <= 1'b0;
        end else begin
            r_bus_req  <= w_issue;
            r_rd_valid <= w_pop && r_bus.rw;
            if (w_issue) r_bus <= w_head;
            if (w_pop && r_bus.rw) begin
                r_rd_data    <= bus_rdata;
                r_rd_pending <= 1'b0;
            end else if (w_push && in_rw) begin
                r_rd_pending <= 1'b1;
            end
            if (w_stray) r_err_stray <= 1'b1;
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_rw    = r_bus.rw;
    assign bus_addr  = r_bus.addr;
    assign bus_data  = r_bus.data;
    assign bus_uds_n = r_bus.uds_n;
    assign bus_lds_n = r_bus.lds_n;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign idle      = w_empty && (r_state == ST_IDLE);
    assign err_stray = r_err_stray;

endmodule

`default_nettype wire
